alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq.sv | 204 ++++++++++++++++++++
 tb/tb_alu_seq.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq -- small sequential ALU with a multi-cycle shift-add multiplier.
//
// Single-cycle ops (ADD/SUB/AND/OR/XOR/SHL/SHR) are accepted in IDLE and
// registered at the sampling edge. MUL captures its operands, then performs
// one shift-add step per cycle for WIDTH cycles before registering the result.
//
// Ports
//   clk       in   clock, all state on rising edge
//   rst       in   synchronous active-high reset
//   start     in   execute opcode on a/b (ignored while busy)
//   opcode    in   3-bit operation select
//   a         in   A_W-bit operand, zero-extended to WIDTH
//   b         in   WIDTH-bit operand
//   busy      out  multiply in progress
//   done      out  one-cycle pulse after the result registers update
//   data_out  out  registered result (modulo 2^WIDTH)
//   zflag     out  registered zero flag of data_out
//   c         out  registered carry / borrow / overflow flag
// ---------------------------------------------------------------------------
module alu_seq #(
   parameter int WIDTH = 8,
   parameter int A_W   = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       opcode,
   input  logic [A_W-1:0]   a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] data_out,
   output logic             zflag,
   output logic             c
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_SHL = 3'b101;
   localparam logic [2:0] OP_SHR = 3'b110;
   localparam logic [2:0] OP_MUL = 3'b111;

   generate
      if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
         $error("alu_seq: WIDTH must be in 2..32");
      end
      if (A_W < 1 || A_W > WIDTH) begin : g_bad_aw
         $error("alu_seq: A_W must be in 1..WIDTH");
      end
   endgenerate

   typedef enum logic {S_IDLE = 1'b0, S_MUL = 1'b1} state_e;

   state_e                 state_q, state_d;
   logic [WIDTH-1:0]       data_q;
   logic                   zflag_q;
   logic                   c_q;
   logic                   done_q;
   logic [2*WIDTH-1:0]     acc_q;   // partial product
   logic [2*WIDTH-1:0]     ma_q;    // multiplicand, shifted left per step
   logic [WIDTH-1:0]       mb_q;    // multiplier, shifted right per step
   logic [CW-1:0]          cnt_q;   // step index 0..WIDTH-1

   logic [WIDTH-1:0]       ext_a;
   logic [WIDTH:0]         sum_w;
   logic [WIDTH:0]         dif_w;
   logic [WIDTH-1:0]       alu_res;
   logic                   alu_c;
   logic [2*WIDTH-1:0]     mul_sum;
   logic                   last_step;

   assign ext_a = WIDTH'(a);

   // ------------------------------------------------------------------
   // Single-cycle ALU
   // ------------------------------------------------------------------
   always_comb begin
      alu_res = '0;
      alu_c   = 1'b0;
      sum_w   = {1'b0, ext_a} + {1'b0, b};
      // Top bit of the widened difference is the borrow (ext_a < b).
      dif_w   = {1'b0, ext_a} - {1'b0, b};
      case (opcode)
         OP_ADD: begin
            alu_res = sum_w[WIDTH-1:0];
            alu_c   = sum_w[WIDTH];
         end
         OP_SUB: begin
            alu_res = dif_w[WIDTH-1:0];
            alu_c   = dif_w[WIDTH];
         end
         OP_AND: alu_res = ext_a & b;
         OP_OR:  alu_res = ext_a | b;
         OP_XOR: alu_res = ext_a ^ b;
         OP_SHL: begin
            alu_res = {b[WIDTH-2:0], 1'b0};
            alu_c   = b[WIDTH-1];
         end
         OP_SHR: begin
            alu_res = {1'b0, b[WIDTH-1:1]};
            alu_c   = b[0];
         end
         default: begin
            alu_res = '0;
            alu_c   = 1'b0;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Shift-add step: the final step's sum is the complete product, so
   // the result is taken straight from mul_sum rather than waiting a
   // further cycle for acc_q.
   // ------------------------------------------------------------------
   assign mul_sum   = acc_q + (mb_q[0] ? ma_q : '0);
   assign last_step = (cnt_q == CW'(WIDTH - 1));

   // ------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start && opcode == OP_MUL) state_d = S_MUL;
         S_MUL:   if (last_step)                 state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // FSM: outputs
   always_comb begin
      busy = (state_q == S_MUL);
   end

   // ------------------------------------------------------------------
   // Datapath and result registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         data_q  <= '0;
         zflag_q <= 1'b0;
         c_q     <= 1'b0;
         done_q  <= 1'b0;
         acc_q   <= '0;
         ma_q    <= '0;
         mb_q    <= '0;
         cnt_q   <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  if (opcode == OP_MUL) begin
                     ma_q  <= {{WIDTH{1'b0}}, ext_a};
                     mb_q  <= b;
                     acc_q <= '0;
                     cnt_q <= '0;
                  end else begin
                     data_q  <= alu_res;
                     zflag_q <= (alu_res == '0);
                     c_q     <= alu_c;
                     done_q  <= 1'b1;
                  end
               end
            end
            S_MUL: begin
               // start is not looked at here: requests while busy are dropped.
               acc_q <= mul_sum;
               ma_q  <= ma_q << 1;
               mb_q  <= mb_q >> 1;
               cnt_q <= cnt_q + CW'(1);
               if (last_step) begin
                  data_q  <= mul_sum[WIDTH-1:0];
                  zflag_q <= (mul_sum[WIDTH-1:0] == '0);
                  c_q     <= |mul_sum[2*WIDTH-1:WIDTH];
                  done_q  <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign done     = done_q;
   assign data_out = data_q;
   assign zflag    = zflag_q;
   assign c        = c_q;

   // A completion always lands in IDLE, so done and busy never overlap.
   a_done_not_busy: assert property (@(posedge clk) disable iff (rst) !(busy && done));

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // WIDTH=8, A_W=5 instance
   logic        start8 = 1'b0;
   logic [2:0]  op8 = '0;
   logic [4:0]  a8 = '0;
   logic [7:0]  b8 = '0;
   logic        busy8, done8, z8, c8;
   logic [7:0]  dout8;

   // WIDTH=16, A_W=8 instance
   logic        start16 = 1'b0;
   logic [2:0]  op16 = '0;
   logic [7:0]  a16 = '0;
   logic [15:0] b16 = '0;
   logic        busy16, done16, z16, c16;
   logic [15:0] dout16;

   alu_seq #(.WIDTH(8), .A_W(5)) u_dut8 (
      .clk(clk), .rst(rst), .start(start8), .opcode(op8), .a(a8), .b(b8),
      .busy(busy8), .done(done8), .data_out(dout8), .zflag(z8), .c(c8));

   alu_seq #(.WIDTH(16), .A_W(8)) u_dut16 (
      .clk(clk), .rst(rst), .start(start16), .opcode(op16), .a(a16), .b(b16),
      .busy(busy16), .done(done16), .data_out(dout16), .zflag(z16), .c(c16));

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      int          sel;
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] d;
      logic        z;
      logic        c;
      string       nm;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(int sel, logic [2:0] op, logic [31:0] av, logic [31:0] bv,
                               logic [31:0] d, logic z, logic cf, string nm);
      vec_t v;
      v.sel = sel; v.op = op; v.a = av; v.b = bv; v.d = d; v.z = z; v.c = cf; v.nm = nm;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   // Reference model: plain integer arithmetic on the opcode definitions.
   task automatic ref_alu(input int w, input logic [2:0] op, input logic [31:0] av,
                          input logic [31:0] bv, output logic [31:0] d,
                          output logic z, output logic cf);
      longint m, x, y, r, cc;
      m = (longint'(1) << w) - 1;
      x = longint'(av);
      y = longint'(bv);
      r = 0; cc = 0;
      case (op)
         3'd0: begin r = x + y; cc = (r >> w) & 1; end
         3'd1: begin r = x - y; cc = (x < y) ? 1 : 0; end
         3'd2: r = x & y;
         3'd3: r = x | y;
         3'd4: r = x ^ y;
         3'd5: begin r = y * 2; cc = (y >> (w - 1)) & 1; end
         3'd6: begin r = y / 2; cc = y & 1; end
         default: begin r = x * y; cc = ((r >> w) != 0) ? 1 : 0; end
      endcase
      d  = 32'(r & m);
      z  = ((r & m) == 0);
      cf = cc[0];
   endtask

   task automatic drive(input int sel, input logic st, input logic [2:0] op,
                        input logic [31:0] av, input logic [31:0] bv);
      if (sel == 0) begin
         start8 = st; op8 = op; a8 = av[4:0]; b8 = bv[7:0];
      end else begin
         start16 = st; op16 = op; a16 = av[7:0]; b16 = bv[15:0];
      end
   endtask

   function automatic logic [31:0] g_dout(int sel);
      return (sel == 0) ? 32'(dout8) : 32'(dout16);
   endfunction
   function automatic logic g_done(int sel);
      return (sel == 0) ? done8 : done16;
   endfunction
   function automatic logic g_busy(int sel);
      return (sel == 0) ? busy8 : busy16;
   endfunction
   function automatic logic g_z(int sel);
      return (sel == 0) ? z8 : z16;
   endfunction
   function automatic logic g_c(int sel);
      return (sel == 0) ? c8 : c16;
   endfunction

   // Issue one op, wait (bounded) for done, check latency, busy profile,
   // result, flags and that done drops the next cycle.
   task automatic run(input int sel, input logic [2:0] op, input logic [31:0] av,
                      input logic [31:0] bv, input logic [31:0] ed, input logic ez,
                      input logic ec, input string nm);
      int w, k;
      logic busy_ok;
      w = (sel == 0) ? 8 : 16;
      @(negedge clk);
      drive(sel, 1'b1, op, av, bv);
      @(negedge clk);
      drive(sel, 1'b0, op, av, bv);
      k = 1;
      busy_ok = 1'b1;
      while (!g_done(sel) && k < 100) begin
         if (!g_busy(sel)) busy_ok = 1'b0;
         @(negedge clk);
         k++;
      end
      chk({nm, " latency"}, k, (op == 3'd7) ? w + 1 : 1);
      if (op == 3'd7) chk({nm, " busy during mul"}, 32'(busy_ok), 32'd1);
      chk({nm, " data"}, g_dout(sel), ed);
      chk({nm, " z"}, 32'(g_z(sel)), 32'(ez));
      chk({nm, " c"}, 32'(g_c(sel)), 32'(ec));
      chk({nm, " busy at done"}, 32'(g_busy(sel)), 32'd0);
      @(negedge clk);
      chk({nm, " done pulse"}, 32'(g_done(sel)), 32'd0);
   endtask

   initial begin
      int k, nd;
      logic [2:0]  rop;
      logic [31:0] ra, rb, ed;
      logic        ez, ec;

      tbl.push_back(mk(0, 3'd0, 1,    1,    8'h02, 0, 0, "ADD 1+1"));
      tbl.push_back(mk(0, 3'd0, 31,   225,  8'h00, 1, 1, "ADD 31+225"));
      tbl.push_back(mk(0, 3'd1, 1,    1,    8'h00, 1, 0, "SUB 1-1"));
      tbl.push_back(mk(0, 3'd1, 0,    1,    8'hFF, 0, 1, "SUB 0-1"));
      tbl.push_back(mk(0, 3'd7, 15,   17,   8'hFF, 0, 0, "MUL 15*17"));
      tbl.push_back(mk(0, 3'd7, 16,   16,   8'h00, 1, 1, "MUL 16*16"));
      tbl.push_back(mk(0, 3'd5, 0,    8'h81, 8'h02, 0, 1, "SHL 81"));
      tbl.push_back(mk(0, 3'd6, 0,    8'h01, 8'h00, 1, 1, "SHR 01"));
      tbl.push_back(mk(0, 3'd2, 8'h0F, 8'hF0, 8'h00, 1, 0, "AND"));
      tbl.push_back(mk(0, 3'd3, 8'h0A, 8'h50, 8'h5A, 0, 0, "OR"));
      tbl.push_back(mk(0, 3'd4, 8'h1F, 8'hFF, 8'hE0, 0, 0, "XOR"));
      tbl.push_back(mk(0, 3'd7, 0,    8'hFF, 8'h00, 1, 0, "MUL 0*FF"));
      tbl.push_back(mk(1, 3'd7, 255,  257,  16'hFFFF, 0, 0, "MUL16 255*257"));
      tbl.push_back(mk(1, 3'd7, 255,  16'hFFFF, 16'hFF01, 0, 1, "MUL16 255*FFFF"));

      // Reset state
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("reset data", g_dout(0), 32'd0);
      chk("reset z/c/busy/done", {28'd0, z8, c8, busy8, done8}, 32'd0);
      chk("reset16 data", g_dout(1), 32'd0);

      // Directed table
      foreach (tbl[i])
         run(tbl[i].sel, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].d, tbl[i].z, tbl[i].c, tbl[i].nm);

      // Randomized against reference model
      for (int i = 0; i < 40; i++) begin
         rop = 3'($urandom_range(0, 7));
         ra  = $urandom_range(0, 31);
         rb  = $urandom_range(0, 255);
         ref_alu(8, rop, ra, rb, ed, ez, ec);
         run(0, rop, ra, rb, ed, ez, ec, $sformatf("rnd8 op%0d a=%0d b=%0d", rop, ra, rb));
      end
      for (int i = 0; i < 8; i++) begin
         rop = 3'($urandom_range(0, 7));
         ra  = $urandom_range(0, 255);
         rb  = $urandom_range(0, 65535);
         ref_alu(16, rop, ra, rb, ed, ez, ec);
         run(1, rop, ra, rb, ed, ez, ec, $sformatf("rnd16 op%0d a=%0d b=%0d", rop, ra, rb));
      end

      // start with changing operands held during a MUL is ignored
      @(negedge clk);
      drive(0, 1'b1, 3'd7, 3, 5);
      @(negedge clk);
      k = 1;
      while (!done8 && k < 100) begin
         drive(0, 1'b1, 3'd0, $urandom_range(0, 31), $urandom_range(0, 255));
         @(negedge clk);
         k++;
      end
      drive(0, 1'b0, 3'd0, 0, 0);
      chk("busy-ignore latency", k, 9);
      chk("busy-ignore data", g_dout(0), 32'h0F);
      nd = done8 ? 1 : 0;
      repeat (4) begin
         @(negedge clk);
         if (done8) nd++;
      end
      chk("busy-ignore done count", nd, 1);

      // Reset in the middle of a MUL
      run(0, 3'd0, 1, 1, 8'h02, 0, 0, "pre-reset ADD");
      @(negedge clk);
      drive(0, 1'b1, 3'd7, 15, 17);
      @(negedge clk);
      drive(0, 1'b0, 3'd0, 0, 0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort data", g_dout(0), 32'd0);
      chk("abort z/c/busy/done", {28'd0, z8, c8, busy8, done8}, 32'd0);
      nd = 0;
      repeat (12) begin
         @(negedge clk);
         if (done8 || busy8) nd++;
      end
      chk("abort no done", nd, 0);
      run(0, 3'd0, 2, 3, 8'h05, 0, 0, "post-reset ADD");

      // start in the same cycle as rst is discarded
      @(negedge clk);
      rst = 1'b1;
      drive(0, 1'b1, 3'd0, 1, 1);
      @(negedge clk);
      rst = 1'b0;
      drive(0, 1'b0, 3'd0, 0, 0);
      @(negedge clk);
      chk("rst+start done", 32'(done8), 32'd0);
      chk("rst+start data", g_dout(0), 32'd0);

      // Back-to-back ADD issued in the MUL done cycle
      @(negedge clk);
      drive(0, 1'b1, 3'd7, 15, 17);
      @(negedge clk);
      drive(0, 1'b0, 3'd0, 0, 0);
      k = 1;
      while (!done8 && k < 100) begin
         @(negedge clk);
         k++;
      end
      chk("b2b mul latency", k, 9);
      chk("b2b mul data", g_dout(0), 32'hFF);
      drive(0, 1'b1, 3'd0, 2, 3);
      @(negedge clk);
      drive(0, 1'b0, 3'd0, 0, 0);
      chk("b2b add done", 32'(done8), 32'd1);
      chk("b2b add data", g_dout(0), 32'h05);
      @(negedge clk);
      chk("b2b add done pulse", 32'(done8), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
